rain_scheduler: RTL



---
 rtl/rain_scheduler.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rain_scheduler.sv
// rain_scheduler: sequencing controller for the falling-character display.
//
// Keeps up to SLOTS falling characters (active, column, y, speed, ASCII).
// On each serviced frame it walks every slot (one per cycle) and drops live
// characters by their speed; every SPAWN_DIV frames it starts a new character
// in the lowest free slot, chosen from a free-running LFSR. Key hits are
// matched against live characters. Spawns and hits are written to the
// character RAM through a one-cycle write strobe.
//
// Ports:
//   pclk, reset                  pixel clock, synchronous active-high reset
//   frame_start, pause           frame pulse, level freeze of fall/spawn
//   key_valid, key_ascii         one-cycle key pulse with uppercase ASCII
//   rd_slot -> rd_active/rd_col/rd_y/rd_ascii   renderer readout of one slot
//   ram_wraddr, ram_data, ram_wren              character RAM write port
//   score, miss                  saturating hit / fall-off counters
//   busy                         high while the controller is not idle
//
// LFSR: 16-bit Fibonacci, left shift, feedback = bit15^bit13^bit12^bit10.
module rain_scheduler #(
  parameter int SLOTS     = 16,
  parameter int COLS      = 80,
  parameter int V_LIMIT   = 464,
  parameter int SPAWN_DIV = 30
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       pause,
  input  logic                       key_valid,
  input  logic [7:0]                 key_ascii,
  input  logic [$clog2(SLOTS)-1:0]   rd_slot,
  output logic                       rd_active,
  output logic [6:0]                 rd_col,
  output logic [8:0]                 rd_y,
  output logic [7:0]                 rd_ascii,
  output logic [11:0]                ram_wraddr,
  output logic [7:0]                 ram_data,
  output logic                       ram_wren,
  output logic [7:0]                 score,
  output logic [7:0]                 miss,
  output logic                       busy
);
  localparam int IW = $clog2(SLOTS);
  localparam int CW = $clog2(SPAWN_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_SPAWN, S_MATCH} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           spawn_cnt_q, spawn_cnt_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    frame_pend_q, frame_pend_d;
  logic                    key_pend_q, key_pend_d;
  logic [7:0]              key_reg_q, key_reg_d;
  logic [SLOTS-1:0]        active_q, active_d;
  logic [SLOTS-1:0][6:0]   col_q, col_d;
  logic [SLOTS-1:0][8:0]   y_q, y_d;
  logic [SLOTS-1:0][2:0]   speed_q, speed_d;
  logic [SLOTS-1:0][7:0]   ascii_q, ascii_d;
  logic [7:0]              score_q, score_d, miss_q, miss_d;
  logic                    ram_wren_q, ram_wren_d;
  logic [11:0]             ram_wraddr_q, ram_wraddr_d;
  logic [7:0]              ram_data_q, ram_data_d;
  logic                    busy_q, busy_d;
  // Spawn decision made in the last UPDATE cycle, committed in SPAWN.
  logic                    spawn_ok_q, spawn_ok_d;
  logic [IW-1:0]           spawn_idx_q, spawn_idx_d;
  logic [2:0]              spawn_speed_q, spawn_speed_d;

  logic [9:0]              upd_sum;
  logic [CW-1:0]           cnt_next;
  logic                    free_found, hit_found;
  logic [IW-1:0]           free_idx, hit_idx;
  logic [4:0]              asc_off;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spawn_cnt_d   = spawn_cnt_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    frame_pend_d  = frame_pend_q | (frame_start & ~pause);
    key_pend_d    = key_pend_q | key_valid;
    key_reg_d     = key_valid ? key_ascii : key_reg_q;
    active_d      = active_q;
    col_d         = col_q;
    y_d           = y_q;
    speed_d       = speed_q;
    ascii_d       = ascii_q;
    score_d       = score_q;
    miss_d        = miss_q;
    ram_wren_d    = 1'b0;
    ram_wraddr_d  = ram_wraddr_q;
    ram_data_d    = ram_data_q;
    spawn_ok_d    = spawn_ok_q;
    spawn_idx_d   = spawn_idx_q;
    spawn_speed_d = spawn_speed_q;
    upd_sum       = '0;
    cnt_next      = '0;
    free_found    = 1'b0;
    free_idx      = '0;
    hit_found     = 1'b0;
    hit_idx       = '0;
    asc_off       = '0;

    case (state_q)
      S_IDLE: begin
        if ((frame_pend_q | frame_start) & ~pause) begin
          state_d      = S_UPDATE;
          idx_d        = '0;
          frame_pend_d = 1'b0;
        end else if (key_pend_q | key_valid) begin
          state_d = S_MATCH;
        end
      end

      S_UPDATE: begin
        upd_sum = {1'b0, y_q[idx_q]} + {7'd0, speed_q[idx_q]};
        if (active_q[idx_q]) begin
          if (upd_sum > 10'(V_LIMIT)) begin
            active_d[idx_q] = 1'b0;
            if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
          end else begin
            y_d[idx_q] = upd_sum[8:0];
          end
        end
        if (idx_q == IW'(SLOTS - 1)) begin
          cnt_next = spawn_cnt_q + 1'b1;
          if (cnt_next == CW'(SPAWN_DIV)) begin
            spawn_cnt_d = '0;
            state_d     = S_SPAWN;
            // Decide now from next-cycle values (post-update occupancy and
            // the LFSR value SPAWN will see) so the RAM strobe is registered
            // out during the SPAWN cycle itself.
            for (int i = SLOTS - 1; i >= 0; i--) begin
              if (!active_d[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
              end
            end
            asc_off       = (lfsr_d[15:11] >= 5'd26) ? lfsr_d[15:11] - 5'd26 : lfsr_d[15:11];
            spawn_ok_d    = free_found;
            spawn_idx_d   = free_idx;
            spawn_speed_d = 3'd1 + {1'b0, lfsr_d[8:7]};
            if (free_found) begin
              ram_wren_d   = 1'b1;
              ram_wraddr_d = {5'd0, ({1'b0, lfsr_d[6:0]} < 8'(COLS)) ? lfsr_d[6:0]
                                                                     : lfsr_d[6:0] - 7'd48};
              ram_data_d   = 8'h41 + {3'd0, asc_off};
            end
          end else begin
            spawn_cnt_d = cnt_next;
            state_d     = S_IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_SPAWN: begin
        // Column and character are already held in the RAM write registers.
        if (spawn_ok_q) begin
          active_d[spawn_idx_q] = 1'b1;
          y_d[spawn_idx_q]      = '0;
          col_d[spawn_idx_q]    = ram_wraddr_q[6:0];
          speed_d[spawn_idx_q]  = spawn_speed_q;
          ascii_d[spawn_idx_q]  = ram_data_q;
        end
        spawn_ok_d = 1'b0;
        state_d    = S_IDLE;
      end

      S_MATCH: begin
        for (int i = SLOTS - 1; i >= 0; i--) begin
          if (active_q[i] && ascii_q[i] == key_reg_q) begin
            hit_found = 1'b1;
            hit_idx   = IW'(i);
          end
        end
        if (hit_found) begin
          active_d[hit_idx] = 1'b0;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          ram_wren_d   = 1'b1;
          ram_wraddr_d = {5'd0, col_q[hit_idx]};
          ram_data_d   = 8'h20;
        end
        // A key arriving in this very cycle stays pending for the next match.
        key_pend_d = key_valid;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      spawn_cnt_q   <= '0;
      lfsr_q        <= 16'hACE1;
      frame_pend_q  <= 1'b0;
      key_pend_q    <= 1'b0;
      key_reg_q     <= '0;
      active_q      <= '0;
      col_q         <= '0;
      y_q           <= '0;
      speed_q       <= '0;
      ascii_q       <= '0;
      score_q       <= '0;
      miss_q        <= '0;
      ram_wren_q    <= 1'b0;
      ram_wraddr_q  <= '0;
      ram_data_q    <= '0;
      busy_q        <= 1'b0;
      spawn_ok_q    <= 1'b0;
      spawn_idx_q   <= '0;
      spawn_speed_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spawn_cnt_q   <= spawn_cnt_d;
      lfsr_q        <= lfsr_d;
      frame_pend_q  <= frame_pend_d;
      key_pend_q    <= key_pend_d;
      key_reg_q     <= key_reg_d;
      active_q      <= active_d;
      col_q         <= col_d;
      y_q           <= y_d;
      speed_q       <= speed_d;
      ascii_q       <= ascii_d;
      score_q       <= score_d;
      miss_q        <= miss_d;
      ram_wren_q    <= ram_wren_d;
      ram_wraddr_q  <= ram_wraddr_d;
      ram_data_q    <= ram_data_d;
      busy_q        <= busy_d;
      spawn_ok_q    <= spawn_ok_d;
      spawn_idx_q   <= spawn_idx_d;
      spawn_speed_q <= spawn_speed_d;
    end
  end

  assign rd_active  = active_q[rd_slot];
  assign rd_col     = col_q[rd_slot];
  assign rd_y       = y_q[rd_slot];
  assign rd_ascii   = ascii_q[rd_slot];
  assign ram_wraddr = ram_wraddr_q;
  assign ram_data   = ram_data_q;
  assign ram_wren   = ram_wren_q;
  assign score      = score_q;
  assign miss       = miss_q;
  assign busy       = busy_q;
endmodule
